// File: rtl/pipe_stage_pkg.sv
// ============================================================================
// Module  : pipe_stage_pkg
// Brief   : Shared state encoding and default widths for the elastic stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_stage_pkg;

    localparam int DEF_DATA_W = 101;
    localparam int DEF_CTRL_W = 3;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // A cycle is starved when the consumer could take a beat but none is offered.
    function automatic logic is_starved(input logic valid, input logic ready);
        return ready & ~valid;
    endfunction

endpackage : pipe_stage_pkg

`default_nettype wire

// File: rtl/pipe_sat_counter.sv
// ============================================================================
// Module  : pipe_sat_counter
// Brief   : Saturating event counter with synchronous clear (clear wins).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : pipe_sat_counter

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module  : pipe_stage_skid
// Brief   : Elastic pipeline stage, 2-entry skid buffer, registered in_ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_state_t      r_state;
    stage_state_t      w_next_state;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [DATA_W-1:0] r_s_data;

    logic w_in_fire;
    logic w_out_valid;
    logic w_out_fire;

    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_valid = (r_state != EMPTY);
    assign w_out_fire  = w_out_valid & out_ready;

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) w_next_state = BUSY;
                BUSY: begin
                    if (w_in_fire && !w_out_fire)      w_next_state = FULL;
                    else if (!w_in_fire && w_out_fire) w_next_state = EMPTY;
                end
                FULL:    if (w_out_fire) w_next_state = BUSY;
                default: w_next_state = EMPTY;
            endcase
        end
    end

    // M always drives the outputs; S only catches the beat accepted while M stalls.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
            r_m_ctrl   <= '0;
            r_m_data   <= '0;
            r_s_ctrl   <= '0;
            r_s_data   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != FULL);
            if (flush) begin
                r_m_ctrl <= '0;
                r_s_ctrl <= '0;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_in_fire) begin
                            r_m_ctrl <= in_ctrl;
                            r_m_data <= in_data;
                        end
                    end
                    BUSY: begin
                        if (w_in_fire && !w_out_fire) begin
                            r_s_ctrl <= in_ctrl;
                            r_s_data <= in_data;
                        end else if (!w_in_fire && w_out_fire) begin
                            r_m_ctrl <= '0;
                        end else if (w_in_fire && w_out_fire) begin
                            r_m_ctrl <= in_ctrl;
                            r_m_data <= in_data;
                        end
                    end
                    FULL: begin
                        if (w_out_fire) begin
                            r_m_ctrl <= r_s_ctrl;
                            r_m_data <= r_s_data;
                            r_s_ctrl <= '0;
                        end
                    end
                    default: begin
                        r_m_ctrl <= '0;
                        r_s_ctrl <= '0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = r_m_ctrl;
    assign out_data  = r_m_data;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (is_starved(w_out_valid, out_ready)),
        .clr   (clr_stats),
        .count (bubble_cnt)
    );

endmodule : pipe_stage_skid

`default_nettype wire
